// File: rtl/cache_line_ctrl.sv
// Direct-mapped cache line controller: lookup, multi-word refill, tag update, hit/miss statistics.
// Optional dirty-line writeback before refill is enabled by defining CACHE_WB_EN.
module cache_line_ctrl #(
  parameter int WORDS_PER_LINE = 8,
  parameter int CNT_W          = $clog2(WORDS_PER_LINE),
  parameter int STAT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              tag_match,
  input  logic              line_valid,
  input  logic              dirty,
  input  logic              mem_ready,
  output logic              tag_wr,
  output logic              data_wr,
  output logic              rdata_wr,
  output logic              mux_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [CNT_W-1:0]  word_idx,
  output logic              req_ack,
  output logic              busy,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    TAG_UPD
`ifdef CACHE_WB_EN
    , WRITEBACK
`endif
  } state_t;

  state_t state;
  logic   relook;
  logic   hit;
  logic   last_word;
  logic   go_wb;

  assign hit       = tag_match & line_valid;
  assign last_word = (word_idx == CNT_W'(WORDS_PER_LINE - 1));

`ifdef CACHE_WB_EN
  assign go_wb = line_valid & dirty;
`else
  logic unused_dirty;
  assign unused_dirty = dirty;
  assign go_wb        = 1'b0;
`endif

  // relook marks the lookup that follows a tag update so it is not counted again
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      relook   <= 1'b0;
      word_idx <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          relook <= 1'b0;
          if (req_valid) state <= LOOKUP;
        end
        LOOKUP: begin
          if (!relook) begin
            if (hit) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + STAT_W'(1);
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + STAT_W'(1);
            end
          end
          if (hit) begin
            state  <= IDLE;
            relook <= 1'b0;
          end else begin
            word_idx <= '0;
`ifdef CACHE_WB_EN
            state    <= go_wb ? WRITEBACK : REFILL;
`else
            state    <= REFILL;
`endif
          end
        end
`ifdef CACHE_WB_EN
        WRITEBACK: begin
          if (mem_ready) begin
            word_idx <= last_word ? '0 : word_idx + CNT_W'(1);
            if (last_word) state <= REFILL;
          end
        end
`endif
        REFILL: begin
          if (mem_ready) begin
            word_idx <= last_word ? '0 : word_idx + CNT_W'(1);
            if (last_word) state <= TAG_UPD;
          end
        end
        TAG_UPD: begin
          relook <= 1'b1;
          state  <= LOOKUP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign rdata_wr = (state == LOOKUP) & hit;
  assign req_ack  = (state == LOOKUP) & hit;
  assign mem_rd   = (state == REFILL);
  assign mux_sel  = (state == REFILL);
  assign data_wr  = (state == REFILL) & mem_ready;
  assign tag_wr   = (state == TAG_UPD);
`ifdef CACHE_WB_EN
  assign mem_wr   = (state == WRITEBACK);
`else
  assign mem_wr   = 1'b0;
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl: reset, hit, clean/stalled/dirty miss, reset mid-refill, saturation.
module tb_cache_line_ctrl;

  localparam int WPL   = 8;
  localparam int CNT_W = 3;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             reset, req_valid, tag_match, line_valid, dirty, mem_ready;
  logic             tag_wr, data_wr, rdata_wr, mux_sel, mem_rd, mem_wr, req_ack, busy;
  logic [CNT_W-1:0] word_idx;
  logic [SW-1:0]    hit_cnt, miss_cnt;

  int vectors    = 0;
  int miscompares = 0;

  cache_line_ctrl #(.WORDS_PER_LINE(WPL), .CNT_W(CNT_W), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .tag_match(tag_match),
    .line_valid(line_valid), .dirty(dirty), .mem_ready(mem_ready),
    .tag_wr(tag_wr), .data_wr(data_wr), .rdata_wr(rdata_wr), .mux_sel(mux_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .word_idx(word_idx), .req_ack(req_ack),
    .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    req_valid = 0; tag_match = 0; line_valid = 0; dirty = 0; mem_ready = 0;
  endtask

  // Runs one missing request to completion; the re-lookup after tag_wr is driven as a hit.
  task automatic drive_miss(input bit stall, input bit dty, output int n_dwr, output int n_mwr,
                            output int n_twr, output int ack_cyc, output int bad);
    int rf_exp = 0;
    int wb_exp = 0;
    bit relook = 0;
    bit got_ack = 0;
    n_dwr = 0; n_mwr = 0; n_twr = 0; ack_cyc = 0; bad = 0;
    for (int c = 1; c <= 80 && !got_ack; c++) begin
      @(negedge clk);
      req_valid  = 1;
      tag_match  = relook;
      line_valid = relook | dty;
      dirty      = dty;
      mem_ready  = stall ? c[0] : 1'b1;
      #1;
      if (mem_rd) begin
        if (word_idx !== rf_exp[CNT_W-1:0] || mux_sel !== 1'b1 || data_wr !== mem_ready) bad++;
        if (data_wr) begin n_dwr++; rf_exp++; end
      end else if (data_wr) bad++;
      if (mem_wr) begin
        n_mwr++;
        if (mux_sel !== 1'b0 || word_idx !== wb_exp[CNT_W-1:0] || n_dwr != 0) bad++;
        if (mem_ready) wb_exp++;
      end
      if (tag_wr) begin n_twr++; relook = 1; end
      if (req_ack) begin got_ack = 1; ack_cyc = c; end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 0; idle_inputs(); req_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if ({tag_wr, data_wr, rdata_wr, mux_sel, mem_rd, mem_wr, req_ack} !== 7'b0) begin
      miscompares++; $display("FAIL reset_strobes got=%b exp=0000000", {tag_wr, data_wr, rdata_wr, mux_sel, mem_rd, mem_wr, req_ack}); end
    vectors++; if (word_idx !== 3'd0) begin miscompares++; $display("FAIL reset_word_idx got=%0d exp=0", word_idx); end
    vectors++; if (hit_cnt !== 3'd0 || miss_cnt !== 3'd0) begin
      miscompares++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    reset = 1; idle_inputs();
  endtask

  task automatic test_hit();
    @(negedge clk);
    req_valid = 1; tag_match = 1; line_valid = 1; #1;
    vectors++; if (busy !== 1'b0 || req_ack !== 1'b0) begin
      miscompares++; $display("FAIL hit_cycle1 got busy=%b ack=%b exp 0/0", busy, req_ack); end
    @(negedge clk); #1;
    vectors++; if (req_ack !== 1'b1 || rdata_wr !== 1'b1 || busy !== 1'b1) begin
      miscompares++; $display("FAIL hit_cycle2 got ack=%b rdata_wr=%b busy=%b exp 1/1/1", req_ack, rdata_wr, busy); end
    @(negedge clk);
    idle_inputs(); #1;
    vectors++; if (busy !== 1'b0 || req_ack !== 1'b0) begin
      miscompares++; $display("FAIL hit_done got busy=%b ack=%b exp 0/0", busy, req_ack); end
    vectors++; if (hit_cnt !== 3'd1 || miss_cnt !== 3'd0) begin
      miscompares++; $display("FAIL hit_counts got=%0d/%0d exp=1/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_miss();
    int nd, nm, nt, ac, bad;
    drive_miss(1'b0, 1'b0, nd, nm, nt, ac, bad);
    vectors++; if (nd != 8) begin miscompares++; $display("FAIL miss_data_wr got=%0d exp=8", nd); end
    vectors++; if (nt != 1) begin miscompares++; $display("FAIL miss_tag_wr got=%0d exp=1", nt); end
    vectors++; if (ac != 12) begin miscompares++; $display("FAIL miss_latency got=%0d exp=12", ac); end
    vectors++; if (nm != 0 || bad != 0) begin miscompares++; $display("FAIL miss_seq got mem_wr=%0d bad=%0d exp 0/0", nm, bad); end
    vectors++; if (miss_cnt !== 3'd1 || hit_cnt !== 3'd1) begin
      miscompares++; $display("FAIL miss_counts got miss=%0d hit=%0d exp 1/1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_stall();
    int nd, nm, nt, ac, bad;
    drive_miss(1'b1, 1'b0, nd, nm, nt, ac, bad);
    vectors++; if (nd != 8) begin miscompares++; $display("FAIL stall_data_wr got=%0d exp=8", nd); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL stall_seq got bad=%0d exp=0", bad); end
    vectors++; if (nt != 1 || ac == 0) begin miscompares++; $display("FAIL stall_finish got tag_wr=%0d ack_cycle=%0d exp 1/nonzero", nt, ac); end
    vectors++; if (miss_cnt !== 3'd2 || hit_cnt !== 3'd1) begin
      miscompares++; $display("FAIL stall_counts got miss=%0d hit=%0d exp 2/1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_writeback();
    int nd, nm, nt, ac, bad;
    drive_miss(1'b0, 1'b1, nd, nm, nt, ac, bad);
`ifdef CACHE_WB_EN
    vectors++; if (nm != 8) begin miscompares++; $display("FAIL wb_mem_wr got=%0d exp=8", nm); end
    vectors++; if (ac != 20) begin miscompares++; $display("FAIL wb_latency got=%0d exp=20", ac); end
`else
    vectors++; if (nm != 0) begin miscompares++; $display("FAIL wb_mem_wr got=%0d exp=0", nm); end
    vectors++; if (ac != 12) begin miscompares++; $display("FAIL wb_latency got=%0d exp=12", ac); end
`endif
    vectors++; if (nd != 8 || nt != 1 || bad != 0) begin
      miscompares++; $display("FAIL wb_seq got data_wr=%0d tag_wr=%0d bad=%0d exp 8/1/0", nd, nt, bad); end
    vectors++; if (miss_cnt !== 3'd3) begin miscompares++; $display("FAIL wb_miss_cnt got=%0d exp=3", miss_cnt); end
  endtask

  task automatic test_reset_mid_refill();
    bit hit5 = 0;
    int tw = 0;
    int bz = 0;
    for (int c = 0; c < 20 && !hit5; c++) begin
      @(negedge clk);
      req_valid = 1; tag_match = 0; line_valid = 0; mem_ready = 1; #1;
      if (mem_rd && word_idx == 3'd5) begin hit5 = 1; reset = 0; end
    end
    vectors++; if (!hit5) begin miscompares++; $display("FAIL mid_reach got=no exp=word_idx 5 in refill"); end
    @(negedge clk); #1;
    vectors++; if (busy !== 1'b0 || word_idx !== 3'd0 || tag_wr !== 1'b0 || data_wr !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got busy=%b idx=%0d tag_wr=%b data_wr=%b exp 0/0/0/0", busy, word_idx, tag_wr, data_wr); end
    vectors++; if (hit_cnt !== 3'd0 || miss_cnt !== 3'd0) begin
      miscompares++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    reset = 1; idle_inputs();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (tag_wr) tw++;
      if (busy) bz++;
    end
    vectors++; if (tw != 0 || bz != 0) begin miscompares++; $display("FAIL mid_after got tag_wr=%0d busy=%0d exp 0/0", tw, bz); end
  endtask

  task automatic test_back_to_back_saturate();
    int acks = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      req_valid = 1; tag_match = 1; line_valid = 1; #1;
      if (req_ack) acks++;
    end
    @(negedge clk);
    idle_inputs(); #1;
    vectors++; if (acks != 9) begin miscompares++; $display("FAIL b2b_acks got=%0d exp=9", acks); end
    vectors++; if (hit_cnt !== 3'd7 || miss_cnt !== 3'd0) begin
      miscompares++; $display("FAIL sat_counts got hit=%0d miss=%0d exp 7/0", hit_cnt, miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_stall();
    test_writeback();
    test_reset_mid_refill();
    test_back_to_back_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
